// File: rtl/rf_pkg.sv
// Shared register-file constants for the writeback path.
package rf_pkg;

    localparam int unsigned RF_AW    = 5;
    localparam int unsigned RF_DW    = 32;
    localparam int unsigned RF_NREGS = 32;

    localparam logic [RF_AW-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester after 'last' wins.
module rr_arbiter #(
    parameter int unsigned  NREQ = 3,
    localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic            en,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx
);

    logic          w_found;
    logic [IW-1:0] w_idx;

    // Scan last+1, last+2, ... modulo NREQ; the first valid requester is granted.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_idx = IW'((32'(last) + k) % NREQ);
            if (en && !w_found && req[w_idx]) begin
                w_found    = 1'b1;
                gnt[w_idx] = 1'b1;
                gnt_idx    = w_idx;
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the single regfile write port among NREQ writeback sources.
// One registered stage into the port; writes to x0 complete but never issue.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = RF_AW,
    parameter int unsigned DW   = RF_DW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 we3,
    output logic [AW-1:0]        wa3,
    output logic [DW-1:0]        wd3,
    output logic [(1<<AW)-1:0]   wr_pend
);

    localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NREG = 1 << AW;

    logic [IW-1:0]   r_last;
    logic            r_we;
    logic [AW-1:0]   r_wa;
    logic [DW-1:0]   r_wd;
    logic [NREG-1:0] r_pend;

    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0]   w_gnt_idx;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_data;
    logic            w_any;
    logic            w_issue;

    rr_arbiter #(
        .NREQ    (NREQ)
    ) u_rr (
        .req     (req_valid),
        .en      (~stall),
        .last    (r_last),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    // Select the granted requester's address and data (grant is one-hot).
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_addr = req_addr[i*AW +: AW];
                w_sel_data = req_data[i*DW +: DW];
            end
        end
    end

    assign w_any   = |w_gnt;
    assign w_issue = w_any && (w_sel_addr != AW'(REG_ZERO));

    // Pointer update and output stage; pending mask tracks the issued address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= IW'(NREQ - 1);
            r_we   <= 1'b0;
            r_wa   <= '0;
            r_wd   <= '0;
            r_pend <= '0;
        end else begin
            if (w_any) begin
                r_last <= w_gnt_idx;
            end
            r_we   <= w_issue;
            r_pend <= w_issue ? (NREG'(1) << w_sel_addr) : '0;
            if (w_issue) begin
                r_wa <= w_sel_addr;
                r_wd <= w_sel_data;
            end
        end
    end

    assign req_ready = w_gnt;
    assign we3       = r_we;
    assign wa3       = r_wa;
    assign wd3       = r_wd;
    assign wr_pend   = r_pend;

endmodule
